// File: rtl/pixel_write_buffer.sv
// Pixel write FIFO between the draw mux and the VGA adapter plot port, with
// off-screen clipping, saturating overflow drop counter and a full-screen clear engine.
module pixel_write_buffer #(
  parameter int          DEPTH        = 16,
  parameter int          ADDR_W       = 4,
  parameter int          X_MAX        = 159,
  parameter int          Y_MAX        = 119,
  parameter logic [2:0]  CLEAR_COLOUR = 3'b000
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic [9:0]        in_x,
  input  logic [9:0]        in_y,
  input  logic [2:0]        in_colour,
  input  logic              in_write,
  input  logic              clear_req,
  input  logic              out_ready,
  output logic [7:0]        out_x,
  output logic [6:0]        out_y,
  output logic [2:0]        out_colour,
  output logic              out_plot,
  output logic              full,
  output logic              empty,
  output logic              clearing,
  output logic [7:0]        drop_count,
  output logic [ADDR_W:0]   count
);

  localparam logic       S_NORMAL = 1'b0;
  localparam logic       S_CLEAR  = 1'b1;

  localparam logic [9:0]        X_LAST10  = 10'(X_MAX);
  localparam logic [9:0]        Y_LAST10  = 10'(Y_MAX);
  localparam logic [7:0]        SX_LAST   = 8'(X_MAX);
  localparam logic [6:0]        SY_LAST   = 7'(Y_MAX);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_FULL  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ZERO  = (ADDR_W+1)'(0);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PTR_ZERO  = ADDR_W'(0);

  logic                state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                full_q, full_d;
  logic                empty_q, empty_d;
  logic [7:0]          drop_q, drop_d;
  logic [7:0]          sx_q, sx_d;
  logic [6:0]          sy_q, sy_d;
  logic [7:0]          out_x_q, out_x_d;
  logic [6:0]          out_y_q, out_y_d;
  logic [2:0]          out_colour_q, out_colour_d;
  logic                out_plot_q, out_plot_d;
  logic [17:0]         mem_q [DEPTH];
  logic [17:0]         head_s;
  logic                wr_ok_s;
  logic                push_s;
  logic                pop_s;

  // Entry layout: {colour, y[6:0], x[7:0]}
  assign head_s  = mem_q[rd_ptr_q];
  assign wr_ok_s = in_write && (in_x <= X_LAST10) && (in_y <= Y_LAST10);

  // Next-state logic for the FIFO, drop counter, clear scan and output registers
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    drop_d       = drop_q;
    sx_d         = sx_q;
    sy_d         = sy_q;
    out_x_d      = out_x_q;
    out_y_d      = out_y_q;
    out_colour_d = out_colour_q;
    out_plot_d   = 1'b0;
    push_s       = 1'b0;
    pop_s        = 1'b0;
    case (state_q)
      S_NORMAL: begin
        if (clear_req) begin
          // Queued pixels and any same-cycle write are discarded uncounted
          state_d  = S_CLEAR;
          wr_ptr_d = PTR_ZERO;
          rd_ptr_d = PTR_ZERO;
          count_d  = CNT_ZERO;
          sx_d     = 8'd0;
          sy_d     = 7'd0;
        end else begin
          pop_s  = out_ready && !empty_q;
          push_s = wr_ok_s && (!full_q || pop_s);
          if (pop_s) begin
            out_x_d      = head_s[7:0];
            out_y_d      = head_s[14:8];
            out_colour_d = head_s[17:15];
            out_plot_d   = 1'b1;
            rd_ptr_d     = rd_ptr_q + PTR_ONE;
          end else begin
            out_plot_d   = 1'b0;
          end
          if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
          end else begin
            wr_ptr_d = wr_ptr_q;
          end
          case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
          endcase
          if (wr_ok_s && full_q && !pop_s && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
          end else begin
            drop_d = drop_q;
          end
        end
      end
      S_CLEAR: begin
        if (out_ready) begin
          out_x_d      = sx_q;
          out_y_d      = sy_q;
          out_colour_d = CLEAR_COLOUR;
          out_plot_d   = 1'b1;
          if (sx_q == SX_LAST) begin
            sx_d = 8'd0;
            if (sy_q == SY_LAST) begin
              sy_d    = 7'd0;
              state_d = S_NORMAL;
            end else begin
              sy_d    = sy_q + 7'd1;
            end
          end else begin
            sx_d = sx_q + 8'd1;
          end
        end else begin
          out_plot_d = 1'b0;
        end
      end
      default: state_d = S_NORMAL;
    endcase
    full_d  = (count_d == CNT_FULL);
    empty_d = (count_d == CNT_ZERO);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q      <= S_NORMAL;
      wr_ptr_q     <= PTR_ZERO;
      rd_ptr_q     <= PTR_ZERO;
      count_q      <= CNT_ZERO;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      drop_q       <= 8'd0;
      sx_q         <= 8'd0;
      sy_q         <= 7'd0;
      out_x_q      <= 8'd0;
      out_y_q      <= 7'd0;
      out_colour_q <= 3'd0;
      out_plot_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      drop_q       <= drop_d;
      sx_q         <= sx_d;
      sy_q         <= sy_d;
      out_x_q      <= out_x_d;
      out_y_q      <= out_y_d;
      out_colour_q <= out_colour_d;
      out_plot_q   <= out_plot_d;
    end
  end

  // FIFO storage; contents need no reset since count gates every read
  always_ff @(posedge CLOCK_50) begin
    if (resetn && push_s) begin
      mem_q[wr_ptr_q] <= {in_colour, in_y[6:0], in_x[7:0]};
    end
  end

  assign out_x      = out_x_q;
  assign out_y      = out_y_q;
  assign out_colour = out_colour_q;
  assign out_plot   = out_plot_q;
  assign full       = full_q;
  assign empty      = empty_q;
  assign clearing   = (state_q == S_CLEAR);
  assign drop_count = drop_q;
  assign count      = count_q;

endmodule

// File: tb/tb_pixel_write_buffer.sv
// Directed bench for pixel_write_buffer: table vectors for single-pixel, clipping and
// push/pop flow, plus sequences for overflow, clear scan with stalls, and reset mid-clear.
module tb_pixel_write_buffer;

  logic       CLOCK_50;
  logic       resetn;
  logic [9:0] in_x;
  logic [9:0] in_y;
  logic [2:0] in_colour;
  logic       in_write;
  logic       clear_req;
  logic       out_ready;
  logic [7:0] out_x;
  logic [6:0] out_y;
  logic [2:0] out_colour;
  logic       out_plot;
  logic       full;
  logic       empty;
  logic       clearing;
  logic [7:0] drop_count;
  logic [4:0] count;

  int checks;
  int errors;

  pixel_write_buffer dut (
    .CLOCK_50   (CLOCK_50),
    .resetn     (resetn),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_colour  (in_colour),
    .in_write   (in_write),
    .clear_req  (clear_req),
    .out_ready  (out_ready),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_colour (out_colour),
    .out_plot   (out_plot),
    .full       (full),
    .empty      (empty),
    .clearing   (clearing),
    .drop_count (drop_count),
    .count      (count)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic       wr;
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] c;
    logic       rdy;
    logic       plot;
    logic [7:0] ox;
    logic [6:0] oy;
    logic [2:0] oc;
    logic [4:0] cnt;
    logic       emp;
  } vec_t;

  vec_t vt [11];

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_out_x"}, int'(out_x), 0);
    check({tag, "_out_y"}, int'(out_y), 0);
    check({tag, "_out_colour"}, int'(out_colour), 0);
    check({tag, "_out_plot"}, int'(out_plot), 0);
    check({tag, "_full"}, int'(full), 0);
    check({tag, "_empty"}, int'(empty), 1);
    check({tag, "_clearing"}, int'(clearing), 0);
    check({tag, "_drop"}, int'(drop_count), 0);
    check({tag, "_count"}, int'(count), 0);
  endtask

  task automatic drive_px(input logic wr, input int x, input int y, input int c);
    in_write  = wr;
    in_x      = 10'(x);
    in_y      = 10'(y);
    in_colour = 3'(c);
  endtask

  initial begin
    int exp_sx;
    int exp_sy;
    int plots;
    int bad;
    int got;
    logic done;
    logic rdy;

    checks = 0;
    errors = 0;
    resetn = 1'b0;
    clear_req = 1'b0;
    out_ready = 1'b0;
    drive_px(1'b0, 0, 0, 0);

    //         wr    x        y        c     rdy   plot  ox      oy      oc    cnt    emp
    vt[0]  = '{1'b1, 10'd10,  10'd20,  3'd5, 1'b1, 1'b0, 8'd0,   7'd0,   3'd0, 5'd1, 1'b0};
    vt[1]  = '{1'b0, 10'd0,   10'd0,   3'd0, 1'b1, 1'b1, 8'd10,  7'd20,  3'd5, 5'd0, 1'b1};
    vt[2]  = '{1'b0, 10'd0,   10'd0,   3'd0, 1'b1, 1'b0, 8'd10,  7'd20,  3'd5, 5'd0, 1'b1};
    vt[3]  = '{1'b1, 10'd160, 10'd5,   3'd1, 1'b1, 1'b0, 8'd10,  7'd20,  3'd5, 5'd0, 1'b1};
    vt[4]  = '{1'b1, 10'd5,   10'd120, 3'd2, 1'b1, 1'b0, 8'd10,  7'd20,  3'd5, 5'd0, 1'b1};
    vt[5]  = '{1'b1, 10'd159, 10'd119, 3'd7, 1'b1, 1'b0, 8'd10,  7'd20,  3'd5, 5'd1, 1'b0};
    vt[6]  = '{1'b1, 10'd3,   10'd4,   3'd2, 1'b1, 1'b1, 8'd159, 7'd119, 3'd7, 5'd1, 1'b0};
    vt[7]  = '{1'b1, 10'd0,   10'd0,   3'd1, 1'b0, 1'b0, 8'd159, 7'd119, 3'd7, 5'd2, 1'b0};
    vt[8]  = '{1'b0, 10'd0,   10'd0,   3'd0, 1'b1, 1'b1, 8'd3,   7'd4,   3'd2, 5'd1, 1'b0};
    vt[9]  = '{1'b0, 10'd0,   10'd0,   3'd0, 1'b1, 1'b1, 8'd0,   7'd0,   3'd1, 5'd0, 1'b1};
    vt[10] = '{1'b0, 10'd0,   10'd0,   3'd0, 1'b1, 1'b0, 8'd0,   7'd0,   3'd1, 5'd0, 1'b1};

    step();
    step();
    check_reset_values("reset");
    resetn = 1'b1;

    for (int i = 0; i < 11; i++) begin
      drive_px(vt[i].wr, int'(vt[i].x), int'(vt[i].y), int'(vt[i].c));
      out_ready = vt[i].rdy;
      step();
      check($sformatf("vec%0d_plot", i), int'(out_plot), int'(vt[i].plot));
      check($sformatf("vec%0d_x", i), int'(out_x), int'(vt[i].ox));
      check($sformatf("vec%0d_y", i), int'(out_y), int'(vt[i].oy));
      check($sformatf("vec%0d_colour", i), int'(out_colour), int'(vt[i].oc));
      check($sformatf("vec%0d_count", i), int'(count), int'(vt[i].cnt));
      check($sformatf("vec%0d_empty", i), int'(empty), int'(vt[i].emp));
      check($sformatf("vec%0d_drop", i), int'(drop_count), 0);
    end

    // Overflow: 20 writes with the sink stalled
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive_px(1'b1, i, i + 1, i % 8);
      step();
    end
    check("ovf_full", int'(full), 1);
    check("ovf_count", int'(count), 16);
    check("ovf_drop", int'(drop_count), 4);

    // Push and pop together while full: accepted, no drop
    drive_px(1'b1, 100, 50, 3);
    out_ready = 1'b1;
    step();
    check("fullpp_plot", int'(out_plot), 1);
    check("fullpp_x", int'(out_x), 0);
    check("fullpp_count", int'(count), 16);
    check("fullpp_drop", int'(drop_count), 4);
    check("fullpp_full", int'(full), 1);

    drive_px(1'b0, 0, 0, 0);
    got = 1;
    for (int cyc = 0; cyc < 40 && got < 17; cyc++) begin
      step();
      if (out_plot === 1'b1) begin
        if (got < 16) begin
          check($sformatf("drain%0d_x", got), int'(out_x), got);
          check($sformatf("drain%0d_y", got), int'(out_y), got + 1);
          check($sformatf("drain%0d_c", got), int'(out_colour), got % 8);
        end else begin
          check("drain16_x", int'(out_x), 100);
          check("drain16_y", int'(out_y), 50);
        end
        got++;
      end
    end
    check("drain_total", got, 17);
    step();
    check("drain_empty", int'(empty), 1);
    check("drain_plot_low", int'(out_plot), 0);

    // Clear with three entries queued; same-cycle write discarded
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_px(1'b1, 40 + i, 30, 6);
      step();
    end
    check("preclear_count", int'(count), 3);
    clear_req = 1'b1;
    out_ready = 1'b1;
    drive_px(1'b1, 7, 7, 7);
    step();
    clear_req = 1'b0;
    drive_px(1'b0, 0, 0, 0);
    check("clear_entered", int'(clearing), 1);
    check("clear_flush_count", int'(count), 0);
    check("clear_flush_empty", int'(empty), 1);

    exp_sx = 0;
    exp_sy = 0;
    plots = 0;
    bad = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < 25000 && !done; cyc++) begin
      rdy = (cyc < 400) ? ((cyc % 2) == 0) : 1'b1;
      out_ready = rdy;
      clear_req = (cyc == 51 || cyc == 600);
      drive_px((cyc % 37) == 5, cyc % 150, cyc % 100, 5);
      step();
      if (out_plot !== rdy) bad++;
      if (out_plot === 1'b1) begin
        if (int'(out_x) != exp_sx || int'(out_y) != exp_sy || out_colour !== 3'd0) bad++;
        plots++;
        if (exp_sx == 159 && exp_sy == 119) begin
          done = 1'b1;
          check("clear_end_clearing", int'(clearing), 0);
        end else begin
          if (clearing !== 1'b1) bad++;
          if (exp_sx == 159) begin
            exp_sx = 0;
            exp_sy++;
          end else begin
            exp_sx++;
          end
        end
      end else if (clearing !== 1'b1) begin
        bad++;
      end
    end
    clear_req = 1'b0;
    drive_px(1'b0, 0, 0, 0);
    out_ready = 1'b1;
    check("clear_done", int'(done), 1);
    check("clear_plots", plots, 19200);
    check("clear_seq_errors", bad, 0);
    step();
    check("postclear_plot", int'(out_plot), 0);
    check("postclear_count", int'(count), 0);
    check("postclear_empty", int'(empty), 1);
    check("postclear_drop", int'(drop_count), 4);

    // Reset during a clear
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    for (int i = 0; i < 100; i++) step();
    check("midclear_active", int'(clearing), 1);
    resetn = 1'b0;
    step();
    check_reset_values("midreset");
    resetn = 1'b1;
    drive_px(1'b1, 1, 1, 3);
    step();
    drive_px(1'b0, 0, 0, 0);
    check("after_reset_count", int'(count), 1);
    step();
    check("after_reset_plot", int'(out_plot), 1);
    check("after_reset_x", int'(out_x), 1);
    check("after_reset_y", int'(out_y), 1);
    check("after_reset_c", int'(out_colour), 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_write_buffer.md
# pixel_write_buffer

Buffers pixel writes from the draw multiplexer and feeds them to the VGA adapter's plot port at the rate the sink accepts. It sits between `draw_mux` (which produces `x`/`y`/`colour`/`writeEn` one pixel per cycle in bursts) and the `draw`/VGA adapter stage. It also clips off-screen coordinates to the 160x120 frame, counts overflow drops, and provides a hardware full-screen clear engine so the game FSMs no longer sweep the frame themselves.

## Interface
Parameters:
- `DEPTH`, 16, FIFO entries; power of two.
- `ADDR_W`, 4, log2(DEPTH).
- `X_MAX`, 159, last valid column.
- `Y_MAX`, 119, last valid row.
- `CLEAR_COLOUR`, 3'b000, colour written by the clear engine.

Ports:
- Reset is `resetn`, synchronous, active-low. The clock is `CLOCK_50`.
- `CLOCK_50`  in  1  system clock.
- `resetn`  in  1  synchronous, active-low reset.
- `in_x`  in  10  pixel column from the draw mux.
- `in_y`  in  10  pixel row from the draw mux.
- `in_colour`  in  3  pixel colour.
- `in_write`  in  1  pixel valid, sampled every cycle. There is no backpressure.
- `clear_req`  in  1  one-cycle pulse that starts a full-screen clear.
- `out_ready`  in  1  the sink can accept a plot this cycle.
- `out_x`  out  8  column to the adapter.
- `out_y`  out  7  row to the adapter.
- `out_colour`  out  3  colour to the adapter.
- `out_plot`  out  1  plot strobe. It is high for exactly one cycle per pixel issued.
- `full`  out  1  FIFO holds DEPTH entries.
- `empty`  out  1  FIFO holds 0 entries.
- `clearing`  out  1  the clear engine is active.
- `drop_count`  out  8  accepted-but-lost pixels; saturates at 255.
- `count`  out  ADDR_W+1  current FIFO occupancy.

## Operation
- **States.** There are two states: `S_NORMAL` (reset state) and `S_CLEAR`.
- **Clipping.** A pixel with `in_x > X_MAX` or `in_y > Y_MAX` is discarded silently. It is not pushed and not counted. The stored pixel uses `in_x[7:0]` and `in_y[6:0]`.
- **Push.** In `S_NORMAL`, a write that is not clipped is pushed if `!full`. It is also pushed if a pop occurs in the same cycle.
- **Overflow drop.** A push attempt while full with no pop is a drop. `drop_count` increments and saturates at 255.
- **Pop/issue.** In `S_NORMAL`, at each edge where `out_ready && !empty`:
  - the head entry loads `out_x`/`out_y`/`out_colour`, and `out_plot<=1`;
  - otherwise `out_plot<=0`, and `out_x`/`out_y`/`out_colour` hold their last values.
- **Entering clear.** `clear_req` in `S_NORMAL` moves the block to `S_CLEAR` at the next edge. On that edge:
  - the FIFO is flushed (`count<=0`), and any entries in it are discarded without counting;
  - the scan counters are set to (0,0).
  - A write present in the same cycle as `clear_req` is discarded.
- **Clear scan.** In `S_CLEAR`:
  - `in_write` is ignored, and nothing is counted;
  - `clear_req` is ignored.
  - Each edge with `out_ready` issues (sx, sy, `CLEAR_COLOUR`) with `out_plot<=1`.
  - sx then advances. When sx=X_MAX, sx wraps to 0 and sy increments (row-major).
  - Issuing (X_MAX, Y_MAX) returns the block to `S_NORMAL` on the same edge.
  - A clear issues exactly (X_MAX+1)*(Y_MAX+1) = 19200 plots.
- **Status outputs.**
  - `clearing` = (state==`S_CLEAR`).
  - `full`, `empty` and `count` are registered and reflect the FIFO after each edge.
- **Pointers.** Read and write pointers are ADDR_W bits and wrap modulo DEPTH. Occupancy is tracked with a separate `count` register.

## Timing
- **Reset values.**
  - Outputs: `out_x`, `out_y`, `out_colour`, `out_plot` = 0; `full` = 0; `empty` = 1; `clearing` = 0; `drop_count` = 0; `count` = 0.
  - Internal: state = `S_NORMAL`; pointers and scan counters = 0.
- **Reset mid-clear.** Reset during a clear aborts it immediately.
- **Latency.** A pixel sampled at edge k (FIFO empty, `out_ready` high) is popped at edge k+1. `out_plot` is then high during cycle k+1..k+2. There is no bypass path.
- **Throughput.** Continuous `in_write` with `out_ready` high sustains one plot per cycle with occupancy steady at 1.
- **Simultaneous push and pop.**
  - When full: the push is accepted, `count` is unchanged, and no drop is counted.
  - When empty: only the push takes effect.
- **Clear timing.**
  - The first clear plot appears at edge k+1 after `clear_req` at edge k, provided `out_ready` is high.
  - With `out_ready` held high, `clearing` deasserts 19200 cycles after entry.
  - `out_ready` low stalls the scan with no skipped pixels.

## Test plan
- **Single pixel.** Write (10,20,3'b101) with `out_ready`=1 → exactly one `out_plot` pulse carrying (10,20,5), starting at the second edge after the write. Afterwards `empty`=1.
- **Overflow.** Hold `out_ready`=0 and write 20 in-range pixels → `full`=1, `count`=16, `drop_count`=4. Then raise `out_ready` → the first 16 pixels are emitted in order.
- **Clipping.** Write (160,5), (5,120) and (159,119) → only (159,119) is emitted; `drop_count` stays 0.
- **Clear.** Pulse `clear_req` with 3 entries queued and `out_ready`=1 → the queued entries are discarded.
  - Plots run (0,0), (1,0) … (159,0), (0,1) … (159,119) in colour 0, 19200 pulses total.
  - `clearing` falls after the last plot.
  - A `clear_req` pulsed mid-scan and `in_write` pulses during the scan have no effect.
- **Stall.** During a clear, toggle `out_ready` every other cycle → no coordinate is skipped or repeated.
- **Reset mid-operation.** Assert `resetn`=0 mid-clear → all outputs return to their reset values at the next edge and `clearing`=0. After reset, a write of (1,1) is emitted normally.
